// File: rtl/tag_button_debouncer.sv
// tag_button_debouncer
// Conditions raw push-button pins for the buttons PIO. Each bit is handled on its own:
//   1. A two-flop synchroniser brings the pin into the clk domain.
//   2. The polarity is normalised so that 1 always means pressed.
//   3. A stability counter debounces the bit.
// The debounced level, and one-cycle press/release pulses, are all registered outputs.
module tag_button_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] buttons_raw,
    output logic [WIDTH-1:0] buttons_clean,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    // Counter wide enough to hold DEBOUNCE_CYCLES-1 without wrapping.
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // The pin level of an unpressed button: the synchroniser resets to it so
    // that leaving reset never looks like a press.
    localparam logic [WIDTH-1:0] RELEASED_PIN = {WIDTH{ACTIVE_LOW}};

    // Per-bit debounce state: idle while the input agrees with the clean level,
    // qualifying while it disagrees.
    typedef enum logic {
        BIT_STABLE  = 1'b0,
        BIT_QUALIFY = 1'b1
    } bit_state_e;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] stable;
    logic [CW-1:0]    cnt [WIDTH];

    bit_state_e       state        [WIDTH];
    logic [WIDTH-1:0] stable_next;
    logic [WIDTH-1:0] press_next;
    logic [WIDTH-1:0] release_next;
    logic [CW-1:0]    cnt_next     [WIDTH];

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so that s2 takes the
        // old s1, not the value s1 is being given on this same edge.
        if (!reset_n) begin
            s1 <= RELEASED_PIN;
            s2 <= RELEASED_PIN;
        end else begin
            s1 <= buttons_raw;
            s2 <= s1;
        end
    end

    // Polarity normalisation: after this, 1 means pressed for every board variant.
    assign n = ACTIVE_LOW ? ~s2 : s2;

    // Next-state logic for each bit's debounce counter, clean level and pulses.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            // NOTE: every output of this block gets a default value first.
            // Without the defaults, the paths that leave a value unassigned would infer latches.
            state[i]        = (n[i] == stable[i]) ? BIT_STABLE : BIT_QUALIFY;
            stable_next[i]  = stable[i];
            press_next[i]   = 1'b0;
            release_next[i] = 1'b0;
            cnt_next[i]     = '0;

            case (state[i])
                BIT_STABLE: begin
                    // Input agrees with the clean level; any partial count is a glitch.
                    cnt_next[i] = '0;
                end
                BIT_QUALIFY: begin
                    if (cnt[i] == CNT_LAST) begin
                        // Held different for the full window: accept the change.
                        stable_next[i]  = n[i];
                        press_next[i]   = n[i];
                        release_next[i] = ~n[i];
                        cnt_next[i]     = '0;
                    end else begin
                        cnt_next[i] = cnt[i] + CNT_ONE;
                    end
                end
                default: begin
                    cnt_next[i] = '0;
                end
            endcase
        end
    end

    // Debounce state and event-pulse registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable        <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            // NOTE: the counter array lives in flops, not RAM.
            // It is cleared here so that a reset in the middle of qualifying
            // throws away the partial count.
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable        <= stable_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    assign buttons_clean = stable;

endmodule

// File: tb/tb_tag_button_debouncer.sv
// Directed bench for tag_button_debouncer, built with DEBOUNCE_CYCLES=4.
// Each stimulus step pushes expected outputs, tagged with the cycle they are due, into a
// scoreboard. Every clock, the entries due in that cycle are popped and compared
// against the DUT outputs.
module tb_tag_button_debouncer;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] buttons_raw;
    logic [W-1:0] buttons_clean;
    logic [W-1:0] press_pulse;
    logic [W-1:0] release_pulse;

    typedef struct {
        int           due;
        string        tag;
        logic [W-1:0] clean;
        logic [W-1:0] press;
        logic [W-1:0] rel;
    } exp_t;

    exp_t sb [$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   e0;

    tag_button_debouncer #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .buttons_raw  (buttons_raw),
        .buttons_clean(buttons_clean),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    // Queue one expectation for the given absolute cycle.
    task automatic expect_at(input int due, input string tag, input logic [W-1:0] clean,
                             input logic [W-1:0] press, input logic [W-1:0] rel);
        exp_t e;
        e.due   = due;
        e.tag   = tag;
        e.clean = clean;
        e.press = press;
        e.rel   = rel;
        sb.push_back(e);
    endtask

    // Queue the same expectation for every cycle in [first, first+len).
    task automatic expect_span(input int first, input int len, input string tag,
                               input logic [W-1:0] clean, input logic [W-1:0] press,
                               input logic [W-1:0] rel);
        for (int k = 0; k < len; k++) expect_at(first + k, tag, clean, press, rel);
    endtask

    // Advance n clocks; sample 1 ns after each rising edge and retire due entries.
    task automatic step(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checks++;
                assert (e.due == cyc)
                else begin
                    errors++;
                    $error("FAIL %s due-cycle got %0d exp %0d", e.tag, cyc, e.due);
                end
                checks++;
                assert (buttons_clean === e.clean)
                else begin
                    errors++;
                    $error("FAIL %s clean @%0d got %h exp %h", e.tag, cyc, buttons_clean, e.clean);
                end
                checks++;
                assert (press_pulse === e.press)
                else begin
                    errors++;
                    $error("FAIL %s press @%0d got %h exp %h", e.tag, cyc, press_pulse, e.press);
                end
                checks++;
                assert (release_pulse === e.rel)
                else begin
                    errors++;
                    $error("FAIL %s release @%0d got %h exp %h", e.tag, cyc, release_pulse, e.rel);
                end
            end
        end
    endtask

    initial begin
        // Reset for 3 cycles with all keys released, then 20 quiet cycles.
        reset_n     = 1'b0;
        buttons_raw = 4'hF;
        expect_span(1, 23, "reset", 4'h0, 4'h0, 4'h0);
        step(3);
        reset_n = 1'b1;
        step(20);

        // Clean press of bit 0: visible after edge 5, pulse gone after edge 6.
        buttons_raw = 4'hE;
        e0 = cyc + 1;
        expect_span(e0, D + 1, "press_wait", 4'h0, 4'h0, 4'h0);
        expect_at(e0 + D + 1, "press_edge", 4'h1, 4'h1, 4'h0);
        expect_span(e0 + D + 2, 2, "press_hold", 4'h1, 4'h0, 4'h0);
        step(D + 4);

        // Release of bit 0.
        buttons_raw = 4'hF;
        e0 = cyc + 1;
        expect_span(e0, D + 1, "release_wait", 4'h1, 4'h0, 4'h0);
        expect_at(e0 + D + 1, "release_edge", 4'h0, 4'h0, 4'h1);
        expect_span(e0 + D + 2, 2, "release_after", 4'h0, 4'h0, 4'h0);
        step(D + 4);

        // Bounce on bit 0: 2 cycles low, 2 high, for 20 cycles; it must never qualify.
        for (int k = 0; k < 10; k++) begin
            buttons_raw = (k % 2 == 0) ? 4'hE : 4'hF;
            expect_span(cyc + 1, 2, "bounce", 4'h0, 4'h0, 4'h0);
            step(2);
        end
        buttons_raw = 4'hE;
        e0 = cyc + 1;
        expect_span(e0, D + 1, "bounce_hold", 4'h0, 4'h0, 4'h0);
        expect_at(e0 + D + 1, "bounce_press", 4'h1, 4'h1, 4'h0);
        expect_at(e0 + D + 2, "bounce_after", 4'h1, 4'h0, 4'h0);
        step(D + 3);
        buttons_raw = 4'hF;
        e0 = cyc + 1;
        expect_span(e0, D + 1, "bounce_rel_wait", 4'h1, 4'h0, 4'h0);
        expect_at(e0 + D + 1, "bounce_rel", 4'h0, 4'h0, 4'h1);
        step(D + 3);

        // Simultaneous press of bits 1 and 3, then simultaneous release.
        buttons_raw = 4'h5;
        e0 = cyc + 1;
        expect_span(e0, D + 1, "simul_wait", 4'h0, 4'h0, 4'h0);
        expect_at(e0 + D + 1, "simul_press", 4'hA, 4'hA, 4'h0);
        expect_at(e0 + D + 2, "simul_hold", 4'hA, 4'h0, 4'h0);
        step(D + 3);
        buttons_raw = 4'hF;
        e0 = cyc + 1;
        expect_span(e0, D + 1, "simul_rel_wait", 4'hA, 4'h0, 4'h0);
        expect_at(e0 + D + 1, "simul_release", 4'h0, 4'h0, 4'hA);
        expect_at(e0 + D + 2, "simul_after", 4'h0, 4'h0, 4'h0);
        step(D + 3);

        // Press bit 2, reset sampled at edge 3 only, key kept held: full re-qualify.
        // Reset edge e0+3 reloads the synchroniser. s2 goes low after e0+5, and the
        // count runs on e0+6..e0+8, so the press is accepted at e0+9.
        buttons_raw = 4'hB;
        e0 = cyc + 1;
        expect_span(e0, 3, "mid_wait", 4'h0, 4'h0, 4'h0);
        step(3);
        reset_n = 1'b0;
        expect_at(e0 + 3, "mid_reset", 4'h0, 4'h0, 4'h0);
        step(1);
        reset_n = 1'b1;
        expect_span(e0 + 4, 5, "mid_requal", 4'h0, 4'h0, 4'h0);
        expect_at(e0 + 9, "mid_press", 4'h4, 4'h4, 4'h0);
        expect_at(e0 + 10, "mid_after", 4'h4, 4'h0, 4'h0);
        step(7);

        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL scoreboard_drain left %0d exp 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tag_button_debouncer.md
# tag_button_debouncer

Conditions the four raw DE1 push-button (KEY) inputs before they reach the Nios buttons PIO. Each bit is synchronised into `clk`, debounced with a per-bit stability counter, polarity-normalised, and presented on `buttons_clean`, which drives the PIO `in_port`. One-cycle press and release event pulses are also produced for fabric logic that must not depend on software polling.

## Interface
Parameters:
- `WIDTH`, 4, number of buttons; legal range ≥1.
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles required to accept a change (10 ms at 50 MHz); legal range ≥1.
- `ACTIVE_LOW`, 1, 1 = raw pin reads 0 when pressed (DE1 KEY); 0 = raw pin reads 1 when pressed.

Ports:
- `clk` in 1: system clock. One clock only.
- `reset_n` in 1: reset, synchronous and active-low. Sampled only on the `clk` rising edge.
- `buttons_raw` in WIDTH: asynchronous pin inputs.
- `buttons_clean` out WIDTH: debounced level, 1 = pressed. Drives the PIO `in_port`.
- `press_pulse` out WIDTH: one-cycle pulse when a bit's clean level goes 0→1.
- `release_pulse` out WIDTH: one-cycle pulse when a bit's clean level goes 1→0.

## Operation
- Per bit, the datapath is a two-flop synchroniser (`s1`→`s2`), polarity normalisation, then the debounce state.
- Normalisation: `n = ACTIVE_LOW ? ~s2 : s2`. After normalisation, 1 always means pressed.
- Each bit holds two state items:
  - `stable`: this is `buttons_clean[i]`.
  - `cnt`: width `$clog2(DEBOUNCE_CYCLES+1)`.
- Per-bit states:
  - STABLE when `n == stable`.
  - QUALIFY when `n != stable`.
- Rules on each rising edge, evaluated in priority order:
  1. `reset_n == 0`: all state takes its reset value.
  2. `n == stable`: `cnt <= 0`. A glitch shorter than the qualify window is discarded.
  3. `n != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= n`, `cnt <= 0`, and the matching event pulse is set for one cycle.
  4. `n != stable` otherwise: `cnt <= cnt + 1`.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so it cannot wrap.
- Bits are fully independent. Simultaneous changes on several bits produce simultaneous pulses in the same cycle.
- A press and a release pulse on the same bit can never coincide.
- The same bit can never pulse in two consecutive cycles when `DEBOUNCE_CYCLES ≥ 2`.

## Timing
- Reset values, applied synchronously:
  - `buttons_clean`, `press_pulse`, `release_pulse`, and all `cnt` = 0.
  - `s1`/`s2` = the released pin level: all-ones if `ACTIVE_LOW`, else zeros. No spurious event occurs on reset exit.
- Latency: a raw change first sampled at edge 0 is in `s2` after edge 1. `buttons_clean` and the pulse update at edge `DEBOUNCE_CYCLES+1`, so total latency is `DEBOUNCE_CYCLES+2` edges.
- Pulses are registered. They are high exactly during the first cycle in which the new `buttons_clean` value is visible, then return to 0.
- Bounce: any return of `n` to `stable` before qualification restarts the count from 0 on the next deviation.
- Reset asserted mid-qualification: the count is lost and `buttons_clean` returns to 0, even if the button is held. After reset deasserts, a held button re-qualifies in full and generates a fresh `press_pulse`.
- Outputs are glitch-free registers and are safe to feed the PIO, whose `readdata` register adds one more cycle.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `ACTIVE_LOW=1`, `WIDTH=4`.
- Reset: hold `reset_n=0` 3 cycles with `buttons_raw=4'hF`, then release → `buttons_clean=0`, no pulses for 20 cycles.
- Clean press: drive `buttons_raw=4'hE` before edge 0 → `buttons_clean=4'h1` and `press_pulse=4'h1` after edge 5. Pulse is 0 after edge 6.
- Bounce reject: on bit 0, toggle raw 0/1 every 2 cycles for 20 cycles, then hold 0 → no pulse during toggling. Press accepted 6 edges after the final hold begins.
- Release: from bit-0 pressed, drive raw bit 0 back to 1 → `release_pulse=4'h1` and `buttons_clean=0` at edge 5.
- Simultaneous: `buttons_raw` 4'hF→4'h5 → `press_pulse=4'hA` in a single cycle, then bits 1 and 3 released together with `release_pulse=4'hA`.
- Mid-qualify reset: press bit 2, assert reset at edge 3 for 1 cycle, keep the button held → no pulse before reset. `press_pulse=4'h4` exactly 6 edges after the reset-exit edge.
